// File: rtl/xcvr_stream_mux.sv
// xcvr_stream_mux: receiver stream serialiser, TX sample skid buffer and
// RX/TX switchover sequencer for the transceiver top level.
// Optional feature: define XCVR_LOOPBACK_EN to add the 'loopback' input,
// which feeds outgoing TX samples back into receiver channel 0.
module xcvr_stream_mux #(
  parameter int NUM_RX      = 2,
  parameter int IQ_WIDTH    = 24,
  parameter int TX_WIDTH    = 16,
  parameter int RAMP_CYCLES = 16,
  parameter int HANG_CYCLES = 1024
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ptt,
  input  logic                       clear_status,
  input  logic [NUM_RX-1:0]          rx_strobe,
  input  logic [NUM_RX*IQ_WIDTH-1:0] rx_data_I,
  input  logic [NUM_RX*IQ_WIDTH-1:0] rx_data_Q,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [2*IQ_WIDTH-1:0]      m_data,
  output logic [2:0]                 m_chan,
  output logic                       m_last,
  output logic [NUM_RX-1:0]          rx_overrun,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [TX_WIDTH-1:0]        s_data_I,
  input  logic [TX_WIDTH-1:0]        s_data_Q,
  input  logic                       tx_strobe,
  output logic [TX_WIDTH-1:0]        tx_out_I,
  output logic [TX_WIDTH-1:0]        tx_out_Q,
  output logic                       tx_underrun,
  output logic                       rx_enable,
  output logic                       tx_enable
`ifdef XCVR_LOOPBACK_EN
  ,
  input  logic                       loopback
`endif
);

  typedef enum logic [1:0] {ST_RX, ST_TX_RAMP, ST_TX, ST_TX_HANG} state_t;

  state_t      state, state_next;
  logic [15:0] count, count_next;
  logic        hang_expire;
  logic        in_rx, in_tx, in_hang;

  logic [IQ_WIDTH-1:0] hold_i [NUM_RX];
  logic [IQ_WIDTH-1:0] hold_q [NUM_RX];
  logic [IQ_WIDTH-1:0] cap_i  [NUM_RX];
  logic [IQ_WIDTH-1:0] cap_q  [NUM_RX];
  logic [NUM_RX-1:0]   pending, strobe_cap, move_mask, ovr_set;

  logic [2:0]            rr_ptr, grant_idx;
  logic                  grant_found, load_out, move_out;
  logic [2*IQ_WIDTH-1:0] grant_data;
  int                    arb_dist, arb_best;

  logic                tx_full, tx_push, tx_pop;
  logic [TX_WIDTH-1:0] tx_hold_i, tx_hold_q, tx_reg_i, tx_reg_q;

`ifdef XCVR_LOOPBACK_EN
  logic                lb_strobe;
  logic [TX_WIDTH-1:0] lb_src_i, lb_src_q;
  logic [IQ_WIDTH-1:0] lb_i, lb_q;

  assign lb_strobe = in_tx && loopback && tx_strobe;
  assign lb_src_i  = tx_full ? tx_hold_i : '0;
  assign lb_src_q  = tx_full ? tx_hold_q : '0;
  assign lb_i      = IQ_WIDTH'($signed(lb_src_i)) << (IQ_WIDTH - TX_WIDTH);
  assign lb_q      = IQ_WIDTH'($signed(lb_src_q)) << (IQ_WIDTH - TX_WIDTH);
`endif

  assign in_rx   = (state == ST_RX);
  assign in_tx   = (state == ST_TX);
  assign in_hang = (state == ST_TX_HANG);

  // Sequencer state and ramp/hang countdown register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_RX;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Sequencer transitions; enables decode from state so they only move on transitions.
  always_comb begin
    state_next  = state;
    count_next  = count;
    rx_enable   = 1'b0;
    tx_enable   = 1'b0;
    hang_expire = 1'b0;
    case (state)
      ST_RX: begin
        rx_enable = 1'b1;
        if (ptt) begin
          state_next = ST_TX_RAMP;
          count_next = 16'(RAMP_CYCLES - 1);
        end
      end
      ST_TX_RAMP: begin
        if (!ptt) begin
          state_next = ST_RX;
        end else if (count == 16'd0) begin
          state_next = ST_TX;
        end else begin
          count_next = count - 16'd1;
        end
      end
      ST_TX: begin
        tx_enable = 1'b1;
        if (!ptt) begin
          state_next = ST_TX_HANG;
          count_next = 16'(HANG_CYCLES - 1);
        end
      end
      ST_TX_HANG: begin
        tx_enable = 1'b1;
        if (ptt) begin
          state_next = ST_TX;
        end else if (count == 16'd0) begin
          state_next  = ST_RX;
          hang_expire = 1'b1;
        end else begin
          count_next = count - 16'd1;
        end
      end
      default: state_next = ST_RX;
    endcase
  end

  // Round-robin grant: nearest pending channel after the last one sent.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_data  = '0;
    arb_best    = NUM_RX;
    arb_dist    = 0;
    for (int c = 0; c < NUM_RX; c++) begin
      arb_dist = c - int'(rr_ptr) - 1;
      if (arb_dist < 0) arb_dist = arb_dist + NUM_RX;
      if (pending[c] && (arb_dist < arb_best)) begin
        arb_best    = arb_dist;
        grant_found = 1'b1;
        grant_idx   = 3'(c);
        grant_data  = {hold_q[c], hold_i[c]};
      end
    end
  end

  assign load_out = !m_valid || m_ready;
  assign move_out = load_out && grant_found;

  // Qualify receiver strobes by state and pick the sample each channel would capture.
  always_comb begin
    for (int c = 0; c < NUM_RX; c++) begin
      strobe_cap[c] = rx_strobe[c] && in_rx;
      cap_i[c]      = rx_data_I[c*IQ_WIDTH +: IQ_WIDTH];
      cap_q[c]      = rx_data_Q[c*IQ_WIDTH +: IQ_WIDTH];
      move_mask[c]  = move_out && (grant_idx == 3'(c));
    end
`ifdef XCVR_LOOPBACK_EN
    if (in_tx && loopback) begin
      strobe_cap[0] = rx_strobe[0] || lb_strobe;
      if (lb_strobe) begin
        cap_i[0] = lb_i;
        cap_q[0] = lb_q;
      end
    end
`endif
    ovr_set = strobe_cap & pending & ~move_mask;
  end

  // Per-channel hold registers, pending bits and sticky overrun flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending    <= '0;
      rx_overrun <= '0;
      for (int c = 0; c < NUM_RX; c++) begin
        hold_i[c] <= '0;
        hold_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_RX; c++) begin
        if (strobe_cap[c]) begin
          hold_i[c]  <= cap_i[c];
          hold_q[c]  <= cap_q[c];
          pending[c] <= 1'b1;
        end else if (move_mask[c]) begin
          pending[c] <= 1'b0;
        end
      end
      rx_overrun <= ovr_set | (rx_overrun & ~{NUM_RX{clear_status}});
    end
  end

  // Output stream register; holds its contents while the sink stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_chan  <= '0;
      m_last  <= 1'b0;
      rr_ptr  <= 3'(NUM_RX - 1);
    end else if (load_out) begin
      m_valid <= grant_found;
      if (grant_found) begin
        m_data <= grant_data;
        m_chan <= grant_idx;
        m_last <= (grant_idx == 3'(NUM_RX - 1));
        rr_ptr <= grant_idx;
      end
    end
  end

  assign s_ready = in_tx && (!tx_full || tx_strobe);
  assign tx_push = s_valid && s_ready;
  assign tx_pop  = in_tx && tx_strobe && tx_full;

  // One-entry TX skid register, flushed when the hang period runs out.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_full   <= 1'b0;
      tx_hold_i <= '0;
      tx_hold_q <= '0;
    end else if (hang_expire) begin
      tx_full <= 1'b0;
    end else if (tx_push) begin
      tx_full   <= 1'b1;
      tx_hold_i <= s_data_I;
      tx_hold_q <= s_data_Q;
    end else if (tx_pop) begin
      tx_full <= 1'b0;
    end
  end

  // Transmit output sample and sticky underrun flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_reg_i    <= '0;
      tx_reg_q    <= '0;
      tx_underrun <= 1'b0;
    end else begin
      if (in_hang) begin
        tx_reg_i <= '0;
        tx_reg_q <= '0;
      end else if (tx_strobe) begin
        tx_reg_i <= tx_pop ? tx_hold_i : '0;
        tx_reg_q <= tx_pop ? tx_hold_q : '0;
      end
      tx_underrun <= (tx_strobe && in_tx && !tx_full) || (tx_underrun && !clear_status);
    end
  end

  assign tx_out_I = in_hang ? '0 : tx_reg_i;
  assign tx_out_Q = in_hang ? '0 : tx_reg_q;

endmodule

// File: doc/xcvr_stream_mux.md
# xcvr_stream_mux

Multi-channel stream and T/R sequencing core for the transceiver top level. Sits between the NUM_RX receiver instances and the ad9866 interface on one side and the host AXI-stream fabric on the other. It serialises strobed receiver I/Q into one valid/ready stream, buffers host TX samples for the transmitter, and runs the RX/TX switchover state machine that drives the converter enables.

## Interface
Parameters:
- NUM_RX, 2: receiver channels, 1..8
- IQ_WIDTH, 24: width of each receiver I and Q sample
- TX_WIDTH, 16: width of each transmit I and Q sample
- RAMP_CYCLES, 16: cycles with both enables low on entry to TX, 1..65535
- HANG_CYCLES, 1024: cycles TX is held after ptt drops, 1..65535

Ports:
- clock  in  1  sample-rate system clock; the only clock
- reset  in  1  synchronous, active-high
- ptt  in  1  transmit request, level
- clear_status  in  1  one-cycle pulse, clears sticky flags
- rx_strobe  in  NUM_RX  per-channel new-sample strobe
- rx_data_I, rx_data_Q  in  NUM_RX*IQ_WIDTH  channel c at bits [c*IQ_WIDTH +: IQ_WIDTH]
- m_valid  out  1;  m_ready  in  1
- m_data  out  2*IQ_WIDTH  {Q,I}, I in low half
- m_chan  out  3  channel index of m_data
- m_last  out  1  m_chan == NUM_RX-1
- rx_overrun  out  NUM_RX  sticky per channel
- s_valid  in  1;  s_ready  out  1
- s_data_I, s_data_Q  in  TX_WIDTH  host TX sample
- tx_strobe  in  1  transmitter consumes one sample
- tx_out_I, tx_out_Q  out  TX_WIDTH
- tx_underrun  out  1  sticky
- rx_enable, tx_enable  out  1  converter enables

## Operation
- State machine RX, TX_RAMP, TX, TX_HANG; reset enters RX.
- RX: rx_enable=1, tx_enable=0. ptt=1 -> TX_RAMP, counter loaded.
- TX_RAMP: both enables 0 for RAMP_CYCLES cycles, then TX. ptt=0 during ramp -> RX directly.
- TX: tx_enable=1, rx_enable=0. ptt=0 -> TX_HANG, counter loaded.
- TX_HANG: tx_enable=1, tx_out forced 0, s_ready=0; ptt=1 -> TX (no ramp); counter expiry -> RX, TX skid register emptied.
- RX capture: only in RX state. Per-channel hold register + pending bit. Strobe on channel with pending set and not being moved out that cycle: new sample overwrites, rx_overrun[c] set.
- Output register loads when empty or when m_valid&&m_ready: next pending channel round-robin starting after last channel sent. Strobe and move-out of same channel in the same cycle: old sample moves out, new one stays pending, no overrun.
- m_data/m_chan stable while m_valid && !m_ready.
- TX path: one-entry skid register. s_ready=1 in TX state when empty, or when full and tx_strobe this cycle. tx_strobe in TX: full -> tx_out takes held sample, else tx_out=0 and tx_underrun set. tx_strobe outside TX: tx_out=0, no flag.
- clear_status clears all sticky flags; a flag-setting event in the same cycle wins.

## Timing
- Reset values: state RX, rx_enable=1, tx_enable=0, m_valid=0, m_data=0, m_chan=0, m_last=0, s_ready=0, tx_out_I/Q=0, flags 0, all pending bits 0, round-robin pointer at channel NUM_RX-1 (first grant channel 0).
- rx_strobe in cycle N -> pending in N+1 -> m_valid in N+2 when output empty.
- Sustained throughput one sample per cycle with m_ready=1.
- tx_strobe in cycle N -> tx_out valid in N+1.
- ptt rise at N -> enables both 0 from N+1, tx_enable=1 from N+1+RAMP_CYCLES.
- ptt fall at N -> rx_enable=1 from N+1+HANG_CYCLES.
- Enables change only at state transitions; never both 1.

## Configuration
- XCVR_LOOPBACK_EN defined: adds input port loopback (1 bit). In TX with loopback=1, each tx_strobe injects the outgoing tx_out sample into channel 0 as a strobe, sign-extended and left-shifted by IQ_WIDTH-TX_WIDTH; channel 0 captures in TX state, other channels do not.
- Undefined: no loopback port; capture only in RX state.

## Test plan
- Reset, then strobe ch0 I=0x000001 Q=0x000002 with m_ready=1 -> m_valid 2 cycles later, m_data=0x000002000001, m_chan=0, m_last=0.
- NUM_RX=2, both channels strobe same cycle, m_ready=1 -> ch0 then ch1 on consecutive cycles, m_last=1 on second.
- m_ready=0, ch1 strobed twice -> rx_overrun[1]=1, second sample delivered; clear_status -> 0.
- ptt=1 at cycle 10, RAMP_CYCLES=16 -> enables 0 cycles 11..26, tx_enable=1 at 27; ptt=0 at 100, HANG_CYCLES=1024 -> rx_enable=1 at 1125.
- TX state, tx_strobe with skid empty -> tx_out=0, tx_underrun=1; push 0x1234/0x5678, tx_strobe -> outputs 0x1234/0x5678.
- With XCVR_LOOPBACK_EN, loopback=1, TX sample I=0x8000 -> channel 0 m_data I=0x800000.
